// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        CAPTURE = 2'd3
    } arb_state_t;

    // Requester ids; also the bit positions in the request vector.
    localparam logic REQ_F = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// whichever requester was not granted last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       any,
    output logic       winner
);

    // Pick the winner from the request vector and the previous grant.
    always_comb begin
        any    = |req;
        winner = REQ_F;
        if (req == 2'b11) begin
            winner = ~last_grant;
        end else if (req[REQ_D]) begin
            winner = REQ_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (F) and data (D).
// Each access runs SETUP -> STROBE -> CAPTURE; the next winner is chosen
// in CAPTURE so back-to-back accesses take three cycles each.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access in flight; arbitrate every cycle
// SETUP   | address/data/write presented, winner's gnt high
// STROBE  | mem_clock high; from_mem captured on the closing edge
// CAPTURE | winner's rvalid high; arbitrate for the next access
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] to_mem,
    input  logic [DATA_W-1:0] from_mem,
    output logic              mem_clock,
    output logic              mem_write
);

    arb_state_t        state, state_n;
    logic              owner, owner_n;
    logic              last_grant, last_grant_n;
    logic              pick_any, pick_winner;
    logic [ADDR_W-1:0] address_n;
    logic [DATA_W-1:0] to_mem_n, f_rdata_n, d_rdata_n;
    logic              mem_clock_n, mem_write_n;
    logic              f_gnt_n, d_gnt_n, f_rvalid_n, d_rvalid_n;

    rr_pick2 u_pick (
        .req        ({d_req, f_req}),
        .last_grant (last_grant),
        .any        (pick_any),
        .winner     (pick_winner)
    );

    // Next-state and next-output logic; every output is a registered copy.
    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        address_n    = address;
        to_mem_n     = to_mem;
        mem_write_n  = mem_write;
        mem_clock_n  = 1'b0;
        f_gnt_n      = 1'b0;
        d_gnt_n      = 1'b0;
        f_rvalid_n   = 1'b0;
        d_rvalid_n   = 1'b0;
        f_rdata_n    = f_rdata;
        d_rdata_n    = d_rdata;

        case (state)
            IDLE, CAPTURE: begin
                mem_write_n = 1'b0;
                state_n     = IDLE;
                if (pick_any) begin
                    state_n      = SETUP;
                    owner_n      = pick_winner;
                    last_grant_n = pick_winner;
                    if (pick_winner == REQ_D) begin
                        address_n   = d_addr;
                        to_mem_n    = d_wdata;
                        mem_write_n = d_write;
                        d_gnt_n     = 1'b1;
                    end else begin
                        address_n   = f_addr;
                        f_gnt_n     = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_n     = STROBE;
                mem_clock_n = 1'b1;
            end
            STROBE: begin
                state_n     = CAPTURE;
                mem_write_n = 1'b0;
                if (owner == REQ_D) begin
                    d_rvalid_n = 1'b1;
                    // A store completes without disturbing the last load result.
                    if (!mem_write) begin
                        d_rdata_n = from_mem;
                    end
                end else begin
                    f_rvalid_n = 1'b1;
                    f_rdata_n  = from_mem;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; fetch wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= REQ_F;
            last_grant <= REQ_D;
            address    <= '0;
            to_mem     <= '0;
            mem_write  <= 1'b0;
            mem_clock  <= 1'b0;
            f_gnt      <= 1'b0;
            d_gnt      <= 1'b0;
            f_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            f_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            address    <= address_n;
            to_mem     <= to_mem_n;
            mem_write  <= mem_write_n;
            mem_clock  <= mem_clock_n;
            f_gnt      <= f_gnt_n;
            d_gnt      <= d_gnt_n;
            f_rvalid   <= f_rvalid_n;
            d_rvalid   <= d_rvalid_n;
            f_rdata    <= f_rdata_n;
            d_rdata    <= d_rdata_n;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level model predicts every
// output each cycle; directed scenarios add hand-computed literal checks,
// then a randomized phase exercises the arbiter with protocol-abiding requesters.
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          f_req, d_req, d_write;
    logic [AW-1:0] f_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          f_gnt, f_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] f_rdata, d_rdata;
    logic [AW-1:0] address;
    logic [DW-1:0] to_mem, from_mem;
    logic          mem_clock, mem_write;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .address   (address),
        .to_mem    (to_mem),
        .from_mem  (from_mem),
        .mem_clock (mem_clock),
        .mem_write (mem_write)
    );

    // Memory device driven by the DUT's strobe; read data only valid while strobed.
    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    always @(posedge mem_clock) if (mem_write) mem[address] <= to_mem;
    assign from_mem = mem_clock ? mem[address] : 8'hEE;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    // Transaction model: an access won at edge s shows gnt in cycle s,
    // strobe in s+1, rvalid in s+2; the next decision is at edge s+3.
    bit            m_act;
    int            m_start;
    bit            m_id;
    bit            m_wr;
    bit            m_last;
    int            m_next;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_tomem, e_frd, e_drd;

    always @(posedge clock) begin
        cyc = cyc + 1;
        if (reset) begin
            m_act   = 1'b0;
            m_last  = 1'b1;
            e_addr  = '0;
            e_tomem = '0;
            e_frd   = '0;
            e_drd   = '0;
            m_next  = cyc + 1;
        end else begin
            if (m_act && cyc == m_start + 1 && m_wr) ref_mem[e_addr] = e_tomem;
            if (m_act && cyc == m_start + 2 && !m_wr) begin
                if (m_id) e_drd = ref_mem[e_addr];
                else      e_frd = ref_mem[e_addr];
            end
            if (cyc >= m_next) begin
                if (f_req || d_req) begin
                    if (f_req && d_req) m_id = ~m_last;
                    else                m_id = d_req;
                    if (m_id) begin
                        e_addr  = d_addr;
                        e_tomem = d_wdata;
                        m_wr    = d_write;
                    end else begin
                        e_addr  = f_addr;
                        m_wr    = 1'b0;
                    end
                    m_act   = 1'b1;
                    m_start = cyc;
                    m_last  = m_id;
                    m_next  = cyc + 3;
                end else begin
                    m_next = cyc + 1;
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clock) begin
        if (cyc >= 1) begin
            int off;
            bit live;
            off  = cyc - m_start;
            live = m_act && off >= 0 && off <= 2;
            chk("f_gnt",     f_gnt,     live && off == 0 && !m_id);
            chk("d_gnt",     d_gnt,     live && off == 0 &&  m_id);
            chk("mem_clock", mem_clock, live && off == 1);
            chk("mem_write", mem_write, live && m_wr && off <= 1);
            chk("f_rvalid",  f_rvalid,  live && off == 2 && !m_id);
            chk("d_rvalid",  d_rvalid,  live && off == 2 &&  m_id);
            chk("address",   address,   e_addr);
            chk("to_mem",    to_mem,    e_tomem);
            chk("f_rdata",   f_rdata,   e_frd);
            chk("d_rdata",   d_rdata,   e_drd);
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; f_req = 1'b0; d_req = 1'b0; d_write = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        mem[5] = 8'hA7; ref_mem[5] = 8'hA7;
        repeat (3) step();
        chk("rst_address", address, 0);
        chk("rst_mclk", mem_clock, 0);
        reset = 1'b0;
        step();

        // Single fetch
        f_req = 1'b1; f_addr = 8'h05;
        step(); chk("fetch_gnt", f_gnt, 1); f_req = 1'b0;
        step(); chk("fetch_mclk", mem_clock, 1); chk("fetch_addr", address, 8'h05);
        chk("fetch_mwr", mem_write, 0);
        step(); chk("fetch_rvalid", f_rvalid, 1); chk("fetch_rdata", f_rdata, 8'hA7);

        // Store then load
        d_req = 1'b1; d_write = 1'b1; d_addr = 8'h20; d_wdata = 8'h3C;
        step(); chk("st_gnt", d_gnt, 1); chk("st_mwr_setup", mem_write, 1); d_req = 1'b0;
        step(); chk("st_mclk", mem_clock, 1); chk("st_mwr_strobe", mem_write, 1);
        step(); chk("st_ack", d_rvalid, 1); chk("st_rdata_kept", d_rdata, 0);
        d_req = 1'b1; d_write = 1'b0;
        step(); chk("ld_gnt", d_gnt, 1); d_req = 1'b0;
        step();
        step(); chk("ld_rvalid", d_rvalid, 1); chk("ld_rdata", d_rdata, 8'h3C);

        // Simultaneous requests held continuously after reset
        reset = 1'b1; step(); step();
        reset = 1'b0; f_req = 1'b1; d_req = 1'b1; f_addr = 8'h01; d_addr = 8'h02; d_write = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("alt_fgnt", f_gnt, (k % 2 == 0) ? 1 : 0);
            chk("alt_dgnt", d_gnt, (k % 2 == 0) ? 0 : 1);
            chk("alt_addr", address, (k % 2 == 0) ? 8'h01 : 8'h02);
            step(); step();
        end
        f_req = 1'b0; d_req = 1'b0;
        step();

        // Reset during STROBE of a store
        d_req = 1'b1; d_write = 1'b1; d_addr = 8'h40; d_wdata = 8'h55;
        step(); chk("rs_gnt", d_gnt, 1); d_req = 1'b0;
        step(); chk("rs_mclk", mem_clock, 1); reset = 1'b1;
        step(); chk("rs_mclk0", mem_clock, 0); chk("rs_mwr0", mem_write, 0);
        chk("rs_addr0", address, 0); chk("rs_norvalid", d_rvalid, 0);
        reset = 1'b0; f_req = 1'b1; d_req = 1'b1; f_addr = 8'h11; d_addr = 8'h12; d_write = 1'b0;
        step(); chk("rs_tie_f", f_gnt, 1); chk("rs_tie_notd", d_gnt, 0); f_req = 1'b0;
        step(); step();
        step(); chk("rs_dgnt", d_gnt, 1); d_req = 1'b0;
        step();
        step(); chk("rs_drdata", d_rdata, 8'h48);

        // Request arriving mid-access
        f_req = 1'b1; f_addr = 8'h30;
        step(); f_req = 1'b0;
        step(); d_req = 1'b1; d_write = 1'b0; d_addr = 8'h31;
        step(); chk("mid_frvalid", f_rvalid, 1); chk("mid_frdata", f_rdata, 8'h6A);
        step(); chk("mid_dgnt", d_gnt, 1); d_req = 1'b0;
        step();
        step(); chk("mid_drdata", d_rdata, 8'h6B); chk("mid_frdata_kept", f_rdata, 8'h6A);

        // Idle stability
        for (int k = 0; k < 10; k++) begin
            step();
            chk("idle_mclk", mem_clock, 0);
            chk("idle_hs", {f_gnt, d_gnt, f_rvalid, d_rvalid}, 0);
            chk("idle_addr", address, 8'h31);
            chk("idle_tomem", to_mem, 8'h55);
        end

        // Randomized requesters
        for (int k = 0; k < 3000; k++) begin
            step();
            reset = ($urandom_range(0, 299) == 0);
            if (f_req && f_gnt) f_req = 1'b0;
            else if (!f_req && $urandom_range(0, 2) == 0) begin
                f_req  = 1'b1;
                f_addr = 8'($urandom_range(0, 31));
            end
            if (d_req && d_gnt) d_req = 1'b0;
            else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_write = 1'($urandom_range(0, 1));
                d_addr  = 8'($urandom_range(0, 31));
                d_wdata = 8'($urandom_range(0, 255));
            end
        end
        reset = 1'b0; f_req = 1'b0; d_req = 1'b0;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port (address, to_mem, from_mem, mem_clock, mem_write) between two requesters: instruction fetch (F) and data load/store (D).
- Sits between ctrl and the memory module and owns the mem_clock strobe.
- Sequences each access as setup, strobe and capture, with a req/gnt/rvalid handshake per requester.
- Arbitrates round-robin when both requesters ask at once.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- f_req  in  1  fetch request; held high until f_gnt is seen
- f_addr  in  ADDR_W  fetch address; must be valid while f_req is high
- f_gnt  out  1  one-cycle pulse: the fetch request has been taken
- f_rvalid  out  1  one-cycle pulse: f_rdata holds the fetched byte
- f_rdata  out  DATA_W  fetched byte; holds its value until the next fetch completes
- d_req  in  1  data request; held high until d_gnt is seen
- d_write  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle pulse: the data request has been taken
- d_rvalid  out  1  one-cycle pulse: load data is valid, or the store is complete
- d_rdata  out  DATA_W  load result; holds its value until the next load completes, unchanged by stores
- address  out  ADDR_W  memory address
- to_mem  out  DATA_W  memory write data
- from_mem  in  DATA_W  memory read data; valid while mem_clock is high
- mem_clock  out  1  memory strobe; memory acts on its rising edge
- mem_write  out  1  memory write enable

Behaviour:
- All outputs are registered.
- States: IDLE, SETUP, STROBE, CAPTURE.
- Reset (any state, including mid-access):
  - state goes to IDLE
  - mem_clock, mem_write, all gnt and rvalid outputs go to 0
  - address, to_mem, f_rdata, d_rdata go to 0
  - last_grant is set to D, so fetch wins the first tie
  - an in-flight access is abandoned and no rvalid is issued
- Arbitration is evaluated in IDLE and in CAPTURE:
  - only one req high: that requester wins
  - both high: the requester that is not last_grant wins
  - neither high: go to (or stay in) IDLE
- On a win:
  - next state is SETUP
  - latch the winner's address, and for D also d_wdata and d_write, into address, to_mem, mem_write (mem_write = 0 for F)
  - record the winner id and update last_grant
- SETUP:
  - assert the winner's gnt for exactly this cycle
  - mem_clock = 0; address, to_mem, mem_write are stable
  - next state is STROBE
- STROBE:
  - mem_clock = 1; mem_write is held
  - on the closing edge, latch from_mem into the winner's rdata (loads and fetches only)
  - next state is CAPTURE
- CAPTURE:
  - mem_clock = 0, mem_write = 0
  - assert the winner's rvalid for exactly this cycle
  - arbitrate as described above
- Latency: req first sampled high at edge E gives gnt in cycle E+1, mem_clock high in E+2, rvalid in E+3.
- Back-to-back throughput: one access every 3 cycles.
- address and to_mem stay stable from SETUP through CAPTURE, and change only when a new access is won.
- The requester deasserts req at the edge after it sees gnt. A req still high in the CAPTURE after its own grant is treated as a new request; this is legal and gives a repeat access.
- Stores: d_rvalid pulses in CAPTURE as the completion ack; d_rdata is unchanged.
- gnt and rvalid are never high for both requesters in the same cycle.
- f_gnt and d_gnt are never high together.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE, SETUP, STROBE, CAPTURE)
  - requester id constants (REQ_F = 0, REQ_D = 1)
- Sub-module rr_pick2: combinational 2-way round-robin picker.
  - inputs: req[1:0], last_grant
  - outputs: any, winner id
- The top level holds the FSM, the latched port registers and the rdata registers.

Test Plan:
- Single fetch: reset, memory[0x05] = 0xA7; f_req = 1, f_addr = 0x05.
  - Required: f_gnt 1 cycle after req is sampled, mem_clock high 1 cycle later with address 0x05 and mem_write = 0, then f_rvalid with f_rdata = 0xA7. No d_* activity.
- Store then load: d_req, d_write = 1, d_addr = 0x20, d_wdata = 0x3C; then d_req, d_write = 0, d_addr = 0x20.
  - Required: mem_write = 1 during SETUP and STROBE of the store, d_rvalid ack with d_rdata unchanged; the load returns d_rdata = 0x3C.
- Simultaneous requests held continuously after reset (f_addr = 0x01, d_addr = 0x02).
  - Required: grants alternate F, D, F, D; each access takes exactly 3 cycles; address follows 0x01, 0x02, 0x01...
- Reset asserted during STROBE of a store to 0x40.
  - Required: next cycle mem_clock = 0, mem_write = 0, address = 0, no d_rvalid; the following tie is granted to F.
- Request arriving mid-access: F in progress, d_req rises during STROBE.
  - Required: d_gnt in the cycle right after F's CAPTURE, with no IDLE gap; f_rdata keeps its value after D completes.
- Idle stability: no requests for 10 cycles.
  - Required: mem_clock stays 0, all gnt and rvalid outputs stay 0, address and to_mem hold their last values.
